// File: rtl/sift_plane_bridge.sv
// Avalon-MM slave bridge moving PLANE_BITS-wide bit-planes between the host bus
// and the SIFT sector core through a TX FIFO (host->core) and an RX FIFO (core->host).
module sift_plane_bridge #(
    parameter int PLANE_BITS = 9,
    parameter int AVL_WIDTH  = 32,
    parameter int FIFO_AW    = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  chipselect_i,
    input  logic                  write_i,
    input  logic                  read_i,
    input  logic [1:0]            address_i,
    input  logic [AVL_WIDTH-1:0]  writedata_i,
    output logic [AVL_WIDTH-1:0]  readdata_o,
    output logic [PLANE_BITS-1:0] plane_o,
    output logic                  plane_valid_o,
    input  logic                  plane_ready_i,
    input  logic [PLANE_BITS-1:0] plane_i,
    input  logic                  plane_valid_i,
    output logic                  plane_ready_o
);
    localparam int WORDS = (PLANE_BITS + AVL_WIDTH - 1) / AVL_WIDTH;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PW    = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BUSW  = WORDS * AVL_WIDTH;

    typedef logic [PLANE_BITS-1:0] plane_t;

    plane_t               tx_mem_q [DEPTH];
    plane_t               tx_mem_d [DEPTH];
    plane_t               rx_mem_q [DEPTH];
    plane_t               rx_mem_d [DEPTH];
    logic [PW-1:0]        tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [PW-1:0]        rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    plane_t               asm_q, asm_d;
    logic [CW-1:0]        wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [15:0]          pcnt_q, pcnt_d;
    logic                 ovf_q, ovf_d, udf_q, udf_d;
    logic [AVL_WIDTH-1:0] rd_q, rd_d;

    logic                 wr_acc, rd_acc, flush;
    logic [PW-1:0]        tx_count, rx_count;
    logic                 tx_empty, tx_full, rx_empty, rx_full;
    logic                 tx_push, tx_pop, rx_push, rx_pop;
    plane_t               asm_next;
    logic [BUSW-1:0]      rx_pad;
    logic [AVL_WIDTH-1:0] rx_word;
    logic [31:0]          status;
    logic                 unused_wdata;

    // Only the low control bits and the plane-covering slots consume writedata.
    assign unused_wdata = ^writedata_i;

    always_comb begin
        wr_acc   = chipselect_i & write_i;
        rd_acc   = chipselect_i & read_i & ~write_i;
        flush    = wr_acc && (address_i == 2'd0) && writedata_i[1];

        tx_count = tx_wp_q - tx_rp_q;
        rx_count = rx_wp_q - rx_rp_q;
        tx_empty = (tx_count == '0);
        tx_full  = (tx_count == PW'(DEPTH));
        rx_empty = (rx_count == '0);
        rx_full  = (rx_count == PW'(DEPTH));

        // Bit b of the plane lives in bus slot b/AVL_WIDTH; bits past the plane are dropped.
        asm_next = asm_q;
        for (int unsigned b = 0; b < PLANE_BITS; b++) begin
            if (wcnt_q == CW'(b / AVL_WIDTH))
                asm_next[b] = writedata_i[b % AVL_WIDTH];
        end

        rx_pad  = BUSW'(rx_mem_q[rx_rp_q[FIFO_AW-1:0]]);
        rx_word = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (rcnt_q == CW'(w))
                rx_word = rx_pad[w*AVL_WIDTH +: AVL_WIDTH];
        end

        status      = '0;
        status[0]   = tx_empty;
        status[1]   = tx_full;
        status[2]   = rx_empty;
        status[3]   = rx_full;
        status[4]   = ovf_q;
        status[5]   = udf_q;
        status[15:8]  = 8'(tx_count);
        status[23:16] = 8'(rx_count);
        status[27:24] = 4'(wcnt_q);

        asm_d    = asm_q;
        wcnt_d   = wcnt_q;
        rcnt_d   = rcnt_q;
        pcnt_d   = pcnt_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        rd_d     = rd_q;
        tx_mem_d = tx_mem_q;
        rx_mem_d = rx_mem_q;
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        tx_push  = 1'b0;
        rx_pop   = 1'b0;
        tx_pop   = ~tx_empty & plane_ready_i;
        rx_push  = plane_valid_i & ~rx_full;

        if (wr_acc && (address_i == 2'd1)) begin
            asm_d = asm_next;
            if (wcnt_q == CW'(WORDS - 1)) begin
                wcnt_d = '0;
                if (tx_full) ovf_d = 1'b1;
                else         tx_push = 1'b1;
            end else begin
                wcnt_d = wcnt_q + CW'(1);
            end
        end

        if (wr_acc && (address_i == 2'd0) && writedata_i[0]) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end

        if (rd_acc) begin
            case (address_i)
                2'd0: rd_d = AVL_WIDTH'(status);
                2'd1: begin
                    if (rx_empty) begin
                        rd_d  = '0;
                        udf_d = 1'b1;
                    end else begin
                        rd_d = rx_word;
                        if (rcnt_q == CW'(WORDS - 1)) begin
                            rcnt_d = '0;
                            rx_pop = 1'b1;
                        end else begin
                            rcnt_d = rcnt_q + CW'(1);
                        end
                    end
                end
                2'd2: rd_d = AVL_WIDTH'(pcnt_q);
                default: rd_d = '0;
            endcase
        end

        if (tx_push) begin
            tx_mem_d[tx_wp_q[FIFO_AW-1:0]] = asm_next;
            tx_wp_d = tx_wp_q + PW'(1);
            pcnt_d  = pcnt_q + 16'd1;
        end
        if (tx_pop) tx_rp_d = tx_rp_q + PW'(1);
        if (rx_push) begin
            rx_mem_d[rx_wp_q[FIFO_AW-1:0]] = plane_i;
            rx_wp_d = rx_wp_q + PW'(1);
        end
        if (rx_pop) rx_rp_d = rx_rp_q + PW'(1);

        // Flush wins over any core-side traffic landing in the same cycle.
        if (flush) begin
            tx_wp_d = '0;
            tx_rp_d = '0;
            rx_wp_d = '0;
            rx_rp_d = '0;
            wcnt_d  = '0;
            rcnt_d  = '0;
            pcnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tx_mem_q[i] <= '0;
                rx_mem_q[i] <= '0;
            end
            tx_wp_q <= '0;
            tx_rp_q <= '0;
            rx_wp_q <= '0;
            rx_rp_q <= '0;
            asm_q   <= '0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            pcnt_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            tx_mem_q <= tx_mem_d;
            rx_mem_q <= rx_mem_d;
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            asm_q    <= asm_d;
            wcnt_q   <= wcnt_d;
            rcnt_q   <= rcnt_d;
            pcnt_q   <= pcnt_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            rd_q     <= rd_d;
        end
    end

    assign readdata_o    = rd_q;
    assign plane_valid_o = ~tx_empty;
    assign plane_o       = tx_empty ? '0 : tx_mem_q[tx_rp_q[FIFO_AW-1:0]];
    assign plane_ready_o = ~rx_full;

endmodule
